falling_char_engine: RTL and testbench

FALLING_CHAR_ENGINE -- requirements
Module: falling_char_engine

---
 rtl/falling_char_engine.sv | 201 ++++++++++++++++++++
 tb/tb_falling_char_engine.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/falling_char_engine.sv
// Game core for a falling-letters typing game: per-lane character positions,
// key matching, miss accounting and the IDLE/PLAY/OVER game flow.
module falling_char_engine #(
  parameter int NUM_LANES    = 8,
  parameter int Y_W          = 10,
  parameter int SPEED_W      = 3,
  parameter int LOWER_BOUND  = 480,
  parameter int MAX_LIVES    = 3,
  parameter int SCORE_W      = 8,
  parameter int MISS_PENALTY = 0,
  localparam int LANE_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 tick,
  input  logic                 spawn_valid,
  output logic                 spawn_ready,
  input  logic [LANE_W-1:0]    spawn_lane,
  input  logic [7:0]           spawn_char,
  input  logic [SPEED_W-1:0]   spawn_speed,
  input  logic                 key_valid,
  input  logic [7:0]           key_ascii,
  input  logic [LANE_W-1:0]    rd_lane,
  output logic [7:0]           rd_char,
  output logic [Y_W-1:0]       rd_y,
  output logic                 rd_active,
  output logic [1:0]           state,
  output logic [SCORE_W-1:0]   score,
  output logic [3:0]           lives,
  output logic [NUM_LANES-1:0] lane_active,
  output logic                 hit,
  output logic                 miss,
  output logic                 gameover
);

  localparam logic [1:0]         ST_IDLE    = 2'd0;
  localparam logic [1:0]         ST_PLAY    = 2'd1;
  localparam logic [1:0]         ST_OVER    = 2'd2;
  localparam logic [LANE_W:0]    LANE_LIMIT = (LANE_W+1)'(NUM_LANES);
  localparam logic [Y_W:0]       Y_LIMIT    = (Y_W+1)'(LOWER_BOUND);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [3:0]         LIVES_INIT = 4'(MAX_LIVES);

  logic [1:0]           state_reg, state_next;
  logic [Y_W-1:0]       lane_y_reg     [NUM_LANES];
  logic [7:0]           lane_char_reg  [NUM_LANES];
  logic [SPEED_W-1:0]   lane_speed_reg [NUM_LANES];
  logic [NUM_LANES-1:0] lane_active_reg;
  logic [SCORE_W-1:0]   score_reg, score_next;
  logic [3:0]           lives_reg, lives_next;
  logic                 hit_reg, hit_next;
  logic                 miss_reg, miss_next;
  logic                 gameover_reg, gameover_next;

  logic                 in_play, game_start, spawn_fire, rd_ok;
  logic                 match_found;
  logic [LANE_W-1:0]    match_idx;
  logic [Y_W-1:0]       match_y;
  logic [NUM_LANES-1:0] lane_hit, lane_miss, lane_spawn;
  logic [Y_W:0]         moved_y [NUM_LANES];
  logic [7:0]           miss_cnt;
  logic [3:0]           lives_after;
  logic [SPEED_W-1:0]   spawn_speed_eff;

  assign in_play         = (state_reg == ST_PLAY);
  assign game_start      = (state_reg == ST_IDLE) && start;
  assign spawn_ready     = in_play && ({1'b0, spawn_lane} < LANE_LIMIT) && !lane_active_reg[spawn_lane];
  assign spawn_fire      = spawn_valid && spawn_ready;
  assign spawn_speed_eff = (spawn_speed == '0) ? SPEED_W'(1) : spawn_speed;

  // Lowest character on screen wins; strict compare keeps the lowest index on ties.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    match_y     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_active_reg[i] && (lane_char_reg[i] == key_ascii) &&
          (!match_found || (lane_y_reg[i] > match_y))) begin
        match_found = 1'b1;
        match_idx   = LANE_W'(i);
        match_y     = lane_y_reg[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign moved_y[gi]    = {1'b0, lane_y_reg[gi]} + (Y_W+1)'(lane_speed_reg[gi]);
      assign lane_hit[gi]   = in_play && key_valid && match_found && (match_idx == LANE_W'(gi));
      // A lane removed by a key this cycle is neither moved nor counted as missed.
      assign lane_miss[gi]  = in_play && tick && lane_active_reg[gi] && !lane_hit[gi] &&
                              (moved_y[gi] >= Y_LIMIT);
      assign lane_spawn[gi] = spawn_fire && (spawn_lane == LANE_W'(gi));
    end
  endgenerate

  always_comb begin
    miss_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      miss_cnt = miss_cnt + 8'(lane_miss[i]);
    end
    lives_after = ({4'b0, lives_reg} > miss_cnt) ? (lives_reg - miss_cnt[3:0]) : 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_PLAY;
      ST_PLAY: if (lives_after == 4'd0) state_next = ST_OVER;
      ST_OVER: if (start) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    score_next    = score_reg;
    lives_next    = lives_reg;
    hit_next      = in_play && key_valid && match_found;
    miss_next     = in_play && (miss_cnt != 8'd0);
    gameover_next = in_play && (state_next == ST_OVER);
    if (game_start) begin
      score_next = '0;
      lives_next = LIVES_INIT;
    end else if (in_play) begin
      lives_next = lives_after;
      if (key_valid) begin
        if (match_found) begin
          if (score_reg != SCORE_MAX) score_next = score_reg + SCORE_W'(1);
        end else if ((MISS_PENALTY != 0) && (score_reg != '0)) begin
          score_next = score_reg - SCORE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_reg    <= '0;
      lives_reg    <= LIVES_INIT;
      hit_reg      <= 1'b0;
      miss_reg     <= 1'b0;
      gameover_reg <= 1'b0;
    end else begin
      score_reg    <= score_next;
      lives_reg    <= lives_next;
      hit_reg      <= hit_next;
      miss_reg     <= miss_next;
      gameover_reg <= gameover_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_active_reg <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_y_reg[i]     <= '0;
        lane_char_reg[i]  <= '0;
        lane_speed_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (game_start || lane_hit[i] || lane_miss[i]) begin
          lane_active_reg[i] <= 1'b0;
          lane_y_reg[i]      <= '0;
          lane_char_reg[i]   <= '0;
          lane_speed_reg[i]  <= '0;
        end else if (lane_spawn[i]) begin
          lane_active_reg[i] <= 1'b1;
          lane_y_reg[i]      <= '0;
          lane_char_reg[i]   <= spawn_char;
          lane_speed_reg[i]  <= spawn_speed_eff;
        end else if (in_play && tick && lane_active_reg[i]) begin
          lane_y_reg[i] <= moved_y[i][Y_W-1:0];
        end
      end
    end
  end

  assign rd_ok       = ({1'b0, rd_lane} < LANE_LIMIT);
  assign rd_char     = rd_ok ? lane_char_reg[rd_lane] : 8'd0;
  assign rd_y        = rd_ok ? lane_y_reg[rd_lane] : '0;
  assign rd_active   = rd_ok ? lane_active_reg[rd_lane] : 1'b0;
  assign state       = state_reg;
  assign score       = score_reg;
  assign lives       = lives_reg;
  assign lane_active = lane_active_reg;
  assign hit         = hit_reg;
  assign miss        = miss_reg;
  assign gameover    = gameover_reg;

endmodule

// File: tb/tb_falling_char_engine.sv
// Bench for falling_char_engine: directed scenarios plus random play checked
// against a lane/score/lives reference model.
module tb_falling_char_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0, tick = 1'b0, spawn_valid = 1'b0, key_valid = 1'b0;
  logic [2:0] spawn_lane = '0, rd_lane = '0, spawn_speed = '0;
  logic [7:0] spawn_char = '0, key_ascii = '0;

  logic       spawn_ready, rd_active, hit, miss, gameover;
  logic [7:0] rd_char, score, lane_active;
  logic [9:0] rd_y;
  logic [1:0] state;
  logic [3:0] lives;

  logic       p_spawn_ready, p_rd_active, p_hit, p_miss, p_gameover;
  logic [7:0] p_rd_char, p_score, p_lane_active;
  logic [9:0] p_rd_y;
  logic [1:0] p_state;
  logic [3:0] p_lives;

  falling_char_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tick(tick),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_lane(spawn_lane),
    .spawn_char(spawn_char), .spawn_speed(spawn_speed),
    .key_valid(key_valid), .key_ascii(key_ascii),
    .rd_lane(rd_lane), .rd_char(rd_char), .rd_y(rd_y), .rd_active(rd_active),
    .state(state), .score(score), .lives(lives), .lane_active(lane_active),
    .hit(hit), .miss(miss), .gameover(gameover)
  );

  falling_char_engine #(.MISS_PENALTY(1)) dut_p (
    .clk(clk), .rst_n(rst_n), .start(start), .tick(tick),
    .spawn_valid(spawn_valid), .spawn_ready(p_spawn_ready), .spawn_lane(spawn_lane),
    .spawn_char(spawn_char), .spawn_speed(spawn_speed),
    .key_valid(key_valid), .key_ascii(key_ascii),
    .rd_lane(rd_lane), .rd_char(p_rd_char), .rd_y(p_rd_y), .rd_active(p_rd_active),
    .state(p_state), .score(p_score), .lives(p_lives), .lane_active(p_lane_active),
    .hit(p_hit), .miss(p_miss), .gameover(p_gameover)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model of the game: plain integers per lane.
  int         m_y [8];
  int         m_spd [8];
  logic [7:0] m_char [8];
  bit         m_act [8];
  int         m_score, m_pscore, m_lives, m_state;
  bit         m_hit, m_miss, m_go, exp_ready, obs_ready;

  function automatic logic [7:0] m_active_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_act[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_act[i] = 0; m_y[i] = 0; m_spd[i] = 0; m_char[i] = 8'h00;
    end
    m_score = 0; m_pscore = 0; m_lives = 3; m_state = 0;
    m_hit = 0; m_miss = 0; m_go = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // One clock of stimulus; updates the model and returns at posedge+1.
  task automatic step(input bit st, input bit tk, input bit sv, input int sl,
                      input logic [7:0] sc, input int ss, input bit kv, input logic [7:0] ka);
    int best;
    int cnt;
    start = st; tick = tk; spawn_valid = sv; spawn_lane = 3'(sl);
    spawn_char = sc; spawn_speed = 3'(ss); key_valid = kv; key_ascii = ka;
    exp_ready = (m_state == 1) && !m_act[sl];
    #1 obs_ready = spawn_ready;
    m_hit = 0; m_miss = 0; m_go = 0;
    if (m_state == 0) begin
      if (st) begin
        for (int i = 0; i < 8; i++) m_act[i] = 0;
        m_score = 0; m_pscore = 0; m_lives = 3; m_state = 1;
      end
    end else if (m_state == 2) begin
      if (st) m_state = 0;
    end else begin
      best = -1;
      if (kv)
        for (int i = 0; i < 8; i++)
          if (m_act[i] && m_char[i] == ka && (best < 0 || m_y[i] > m_y[best])) best = i;
      if (kv) begin
        if (best >= 0) begin
          if (m_score < 255) m_score++;
          if (m_pscore < 255) m_pscore++;
        end else if (m_pscore > 0) m_pscore--;
      end
      cnt = 0;
      if (tk)
        for (int i = 0; i < 8; i++)
          if (m_act[i] && i != best) begin
            if (m_y[i] + m_spd[i] >= 480) begin m_act[i] = 0; cnt++; end
            else m_y[i] = m_y[i] + m_spd[i];
          end
      if (best >= 0) m_act[best] = 0;
      if (sv && exp_ready) begin
        m_act[sl] = 1; m_y[sl] = 0; m_char[sl] = sc; m_spd[sl] = (ss == 0) ? 1 : ss;
      end
      m_lives = (m_lives > cnt) ? m_lives - cnt : 0;
      m_hit = (best >= 0);
      m_miss = (cnt > 0);
      if (m_lives == 0) begin m_state = 2; m_go = 1; end
    end
    @(posedge clk);
    #1;
    start = 0; tick = 0; spawn_valid = 0; key_valid = 0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (state !== 2'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
    n_checks++; if (score !== 8'd0) $display("FAIL reset_score: got %0d want 0", score); else n_pass++;
    n_checks++; if (lives !== 4'd3) $display("FAIL reset_lives: got %0d want 3", lives); else n_pass++;
    n_checks++; if (lane_active !== 8'h00) $display("FAIL reset_lanes: got %h want 00", lane_active); else n_pass++;
    n_checks++; if ({hit, miss, gameover} !== 3'b000) $display("FAIL reset_pulses: got %b want 000", {hit, miss, gameover}); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      rd_lane = 3'(i);
      #1;
      n_checks++;
      if ({rd_active, rd_char, rd_y} !== 19'd0)
        $display("FAIL reset_rd lane %0d: got act=%b char=%h y=%0d want all 0", i, rd_active, rd_char, rd_y);
      else n_pass++;
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_basic_fall();
    do_reset();
    step(1, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    n_checks++; if (state !== 2'd1) $display("FAIL start_play: got %0d want 1", state); else n_pass++;
    step(0, 0, 1, 2, 8'h41, 4, 0, 8'h00);
    n_checks++; if (obs_ready !== 1'b1) $display("FAIL basic_ready: got %b want 1", obs_ready); else n_pass++;
    repeat (3) step(0, 1, 0, 0, 8'h00, 0, 0, 8'h00);
    rd_lane = 3'd2;
    #1;
    n_checks++; if (rd_y !== 10'd12) $display("FAIL basic_y: got %0d want 12", rd_y); else n_pass++;
    n_checks++; if (rd_char !== 8'h41) $display("FAIL basic_char: got %h want 41", rd_char); else n_pass++;
    n_checks++; if (lane_active !== 8'h04) $display("FAIL basic_lanes: got %h want 04", lane_active); else n_pass++;
    n_checks++; if (score !== 8'd0) $display("FAIL basic_score: got %0d want 0", score); else n_pass++;
  endtask

  task automatic test_hit_priority();
    do_reset();
    step(1, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    step(0, 0, 1, 5, 8'h42, 4, 0, 8'h00);
    repeat (15) step(0, 1, 0, 0, 8'h00, 0, 0, 8'h00);
    step(0, 0, 1, 0, 8'h42, 4, 0, 8'h00);
    repeat (10) step(0, 1, 0, 0, 8'h00, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00, 0, 1, 8'h42);
    n_checks++; if (lane_active !== 8'h01) $display("FAIL prio_lanes: got %h want 01", lane_active); else n_pass++;
    n_checks++; if (score !== 8'd1) $display("FAIL prio_score: got %0d want 1", score); else n_pass++;
    n_checks++; if (hit !== 1'b1) $display("FAIL prio_hit: got %b want 1", hit); else n_pass++;
    rd_lane = 3'd0;
    #1;
    n_checks++; if (rd_y !== 10'd40) $display("FAIL prio_keep_y: got %0d want 40", rd_y); else n_pass++;
    step(0, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    n_checks++; if (hit !== 1'b0) $display("FAIL prio_hit_pulse: got %b want 0", hit); else n_pass++;
  endtask

  task automatic test_miss_gameover();
    do_reset();
    step(1, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 0, 8'h45, 4, 0, 8'h00);
      repeat (119) step(0, 1, 0, 0, 8'h00, 0, 0, 8'h00);
      rd_lane = 3'd0;
      #1;
      n_checks++; if (rd_y !== 10'd476) $display("FAIL miss_pre_y[%0d]: got %0d want 476", k, rd_y); else n_pass++;
      step(0, 1, 0, 0, 8'h00, 0, 0, 8'h00);
      n_checks++; if (lives !== 4'(2 - k)) $display("FAIL miss_lives[%0d]: got %0d want %0d", k, lives, 2 - k); else n_pass++;
      n_checks++; if ({miss, lane_active[0]} !== 2'b10) $display("FAIL miss_pulse[%0d]: got miss=%b act=%b want 1/0", k, miss, lane_active[0]); else n_pass++;
    end
    n_checks++; if ({state, gameover} !== 3'b101) $display("FAIL over_enter: got state=%0d go=%b want 2/1", state, gameover); else n_pass++;
    step(0, 1, 1, 3, 8'h41, 2, 1, 8'h41);
    n_checks++; if ({gameover, miss, state, lane_active} !== {2'b00, 2'd2, 8'h00}) $display("FAIL over_hold: got go=%b miss=%b state=%0d lanes=%h want 0/0/2/00", gameover, miss, state, lane_active); else n_pass++;
    step(1, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    n_checks++; if (state !== 2'd0) $display("FAIL over_to_idle: got %0d want 0", state); else n_pass++;
  endtask

  task automatic test_key_and_tick();
    do_reset();
    step(1, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    step(0, 0, 1, 1, 8'h43, 2, 0, 8'h00);
    repeat (239) step(0, 1, 0, 0, 8'h00, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00, 0, 1, 8'h43);
    n_checks++; if ({hit, miss} !== 2'b10) $display("FAIL keytick_pulses: got hit=%b miss=%b want 1/0", hit, miss); else n_pass++;
    n_checks++; if (lives !== 4'd3) $display("FAIL keytick_lives: got %0d want 3", lives); else n_pass++;
    n_checks++; if ({lane_active, score} !== {8'h00, 8'd1}) $display("FAIL keytick_state: got lanes=%h score=%0d want 00/1", lane_active, score); else n_pass++;
  endtask

  task automatic test_score_saturation();
    do_reset();
    step(1, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00, 0, 1, 8'h5A);
    n_checks++; if (p_score !== 8'd0) $display("FAIL penalty_floor: got %0d want 0", p_score); else n_pass++;
    for (int k = 0; k < 256; k++) begin
      step(0, 0, 1, 0, 8'h44, 1, 0, 8'h00);
      step(0, 0, 0, 0, 8'h00, 0, 1, 8'h44);
    end
    n_checks++; if ({score, hit} !== {8'd255, 1'b1}) $display("FAIL score_sat: got score=%0d hit=%b want 255/1", score, hit); else n_pass++;
    step(0, 0, 0, 0, 8'h00, 0, 1, 8'h5A);
    n_checks++; if ({score, p_score} !== {8'd255, 8'd254}) $display("FAIL wrong_key: got %0d/%0d want 255/254", score, p_score); else n_pass++;
  endtask

  task automatic test_spawn_busy_and_reset();
    do_reset();
    step(1, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    step(0, 0, 1, 3, 8'h46, 3, 0, 8'h00);
    repeat (2) step(0, 1, 0, 0, 8'h00, 0, 0, 8'h00);
    step(0, 0, 1, 3, 8'h47, 5, 0, 8'h00);
    n_checks++; if (obs_ready !== 1'b0) $display("FAIL busy_ready: got %b want 0", obs_ready); else n_pass++;
    rd_lane = 3'd3;
    #1;
    n_checks++; if ({rd_char, rd_y} !== {8'h46, 10'd6}) $display("FAIL busy_lane: got char=%h y=%0d want 46/6", rd_char, rd_y); else n_pass++;
    step(1, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    n_checks++; if (state !== 2'd1) $display("FAIL start_in_play: got %0d want 1", state); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({state, lane_active, rd_active} !== {2'd0, 8'h00, 1'b0}) $display("FAIL async_reset: got state=%0d lanes=%h want 0/00", state, lane_active); else n_pass++;
    do_reset();
    step(1, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    n_checks++; if ({state, lives, lane_active} !== {2'd1, 4'd3, 8'h00}) $display("FAIL restart: got state=%0d lives=%0d lanes=%h want 1/3/00", state, lives, lane_active); else n_pass++;
  endtask

  task automatic test_random_play();
    logic [37:0] got, want;
    int ln;
    do_reset();
    step(1, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 7)), 8'h41 + 8'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
           $urandom_range(0, 2) == 0, 8'h41 + 8'($urandom_range(0, 4)));
      n_checks++;
      if (obs_ready !== exp_ready) $display("FAIL rand_ready cyc %0d: got %b want %b", c, obs_ready, exp_ready); else n_pass++;
      ln = int'($urandom_range(0, 7));
      rd_lane = 3'(ln);
      #1;
      got  = {state, score, lives, lane_active, hit, miss, gameover, p_score};
      want = {2'(m_state), 8'(m_score), 4'(m_lives), m_active_vec(), m_hit, m_miss, m_go, 8'(m_pscore)};
      n_checks++;
      if (got !== want) $display("FAIL rand_state cyc %0d: got %h want %h", c, got, want); else n_pass++;
      if (m_act[ln]) begin
        n_checks++;
        if ({rd_active, rd_char, rd_y} !== {1'b1, m_char[ln], 10'(m_y[ln])})
          $display("FAIL rand_rd cyc %0d lane %0d: got char=%h y=%0d want %h/%0d", c, ln, rd_char, rd_y, m_char[ln], m_y[ln]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_fall();
    test_hit_priority();
    test_miss_gameover();
    test_key_and_tick();
    test_score_saturation();
    test_spawn_busy_and_reset();
    test_random_play();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
